mbist_march_ctrl: RTL and testbench
===================================

# mbist_march_ctrl

March C- built-in self-test controller that sits directly upstream of the fault-injectable word memory. It drives the memory's data, address, enable and write/read-bar inputs, and checks the memory's registered read output. On a start pulse it runs the full six-element March C- sequence over a configurable address range. It reports pass/fail, the first failing location and a saturating error count.

## Interface
- D_W, 32, memory data width
- A_W, 16, memory address width
- N_WORDS, 16, number of words tested: addresses 0 .. N_WORDS-1; N_WORDS ≥ 2, ≤ 2^A_W
- BG, '0, data background; "write 0" drives BG, "write 1" drives ~BG
- i_clk  in  1  single clock, all logic on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  start pulse; honoured only in IDLE or DONE
- o_busy  out  1  high while the test runs
- o_done  out  1  high from test completion until the next accepted start
- o_fail  out  1  sticky; set by any read mismatch during the current run
- o_fail_elem  out  3  March element index (0-5) of the first mismatch
- o_fail_addr  out  A_W  address of the first mismatch
- o_fail_data  out  D_W  read data captured at the first mismatch
- o_err_cnt  out  16  count of mismatching reads, saturates at 16'hFFFF
- o_mem_data  out  D_W  write data to the memory
- o_mem_addr  out  A_W  address to the memory
- o_mem_en  out  1  memory enable
- o_mem_wr_rbar  out  1  1 = write, 0 = read
- i_mem_out  in  D_W  memory read data, registered by the memory, one-cycle latency

## Operation
- Elements:
  - M0 ⇑(w0)
  - M1 ⇑(r0,w1)
  - M2 ⇑(r1,w0)
  - M3 ⇓(r0,w1)
  - M4 ⇓(r1,w0)
  - M5 ⇑(r0)
- ⇑ runs addresses 0 → N_WORDS-1; ⇓ runs N_WORDS-1 → 0.
- Within one address, all operations of the element complete before the address advances.
- States:
  - IDLE: i_start → RUN, counters cleared.
  - RUN: steps elem/addr/op.
  - After the last op of M5 at address N_WORDS-1 completes → DONE.
  - DONE: i_start → RUN.
- Starting a run clears o_fail, o_err_cnt, o_fail_elem, o_fail_addr and o_fail_data.
- Each memory operation occupies one 2-cycle slot:
  - Issue cycle: o_mem_* driven.
  - Hold cycle: o_mem_* unchanged.
  - For reads, i_mem_out is compared against the expected value (BG or ~BG) at the rising edge that ends the hold cycle.
- On a mismatch, o_err_cnt increments (saturating).
- On the first mismatch of a run, o_fail sets, and elem/addr/data are captured in the same edge. Later mismatches do not overwrite the capture.
- The test always runs to completion; there is no early abort on fail.
- When not in RUN: o_mem_en = 0, o_mem_wr_rbar = 0, o_mem_data = 0, o_mem_addr = 0.
- i_start while in RUN is ignored.

## Timing
- Reset values: all outputs 0. State = IDLE. Reset takes effect immediately (asynchronous), including mid-run; the memory bus goes idle in the same instant.
- Start latency: i_start high at edge E moves the block to RUN. From the cycle after E, o_busy = 1 and the first slot (M0 w0 @ addr 0) is driven.
- Total operations = 10·N_WORDS; total RUN cycles = 20·N_WORDS. For N_WORDS = 16 this is 320 cycles.
- o_busy falls and o_done rises on the same edge that ends the final hold cycle.
- Error count, fail flag and capture registers all update at the edge ending the read slot. The results are visible in the next cycle.
- Address wrap: at the element boundary, ⇑ end (N_WORDS-1) and ⇓ end (0) move to the next element's start address with no idle slot.

## Structure
- mbist_pkg holds:
  - state enum (IDLE, RUN, DONE)
  - element index type and constants M0..M5
  - per-element op table: op count, op kind (R/W), data polarity, and direction
- Sub-module mbist_addr_gen: loadable up/down address counter with parameter N_WORDS. It provides load_up/load_down/step inputs and a last-address flag.
- The controller FSM, comparator and result registers live in mbist_march_ctrl.

## Test plan
- Reset/idle: hold i_rst, then release with no start → all outputs 0 and the memory bus idle.
- Fault-free behavioural memory, N_WORDS = 16, BG = 0 → first slot writes 32'h0 @ 0. o_done rises 320 cycles after start. o_fail = 0, o_err_cnt = 0.
- Stuck-at-0 on bit 5 @ addr 3 → o_fail = 1, o_fail_elem = 2, o_fail_addr = 3, o_fail_data = 32'hFFFF_FFDF, o_err_cnt = 2.
- Stuck-at-1 on bit 0 @ addr 15 → o_fail_elem = 1, o_fail_addr = 15, o_fail_data = 32'h0000_0001, o_err_cnt = 3.
- Assert i_rst for 1 cycle at cycle 100 of a run → all outputs 0 immediately. A subsequent start on a fault-free memory completes in 320 cycles with o_fail = 0.
- Pulse i_start mid-run → ignored, and completion timing is unchanged. Restart from DONE after a failing run → fail flag and captures clear on the start edge.

Source files
------------

// File: rtl/mbist_pkg.sv
// Shared types and the March C- element table for the MBIST controller.
// Each element is described by op count, op kinds, data polarities and direction.
package mbist_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    typedef logic [2:0] elem_t;

    localparam elem_t M0 = 3'd0;
    localparam elem_t M1 = 3'd1;
    localparam elem_t M2 = 3'd2;
    localparam elem_t M3 = 3'd3;
    localparam elem_t M4 = 3'd4;
    localparam elem_t M5 = 3'd5;

    // wr[i]/pol[i] describe op i of the element; pol 1 means ~BG
    typedef struct packed {
        logic       two_ops;
        logic [1:0] wr;
        logic [1:0] pol;
        logic       down;
    } elem_info_t;

    function automatic elem_info_t elem_info(input elem_t e);
        elem_info_t info;
        info = '0;
        case (e)
            M0: info = '{two_ops: 1'b0, wr: 2'b01, pol: 2'b00, down: 1'b0};
            M1: info = '{two_ops: 1'b1, wr: 2'b10, pol: 2'b10, down: 1'b0};
            M2: info = '{two_ops: 1'b1, wr: 2'b10, pol: 2'b01, down: 1'b0};
            M3: info = '{two_ops: 1'b1, wr: 2'b10, pol: 2'b10, down: 1'b1};
            M4: info = '{two_ops: 1'b1, wr: 2'b10, pol: 2'b01, down: 1'b1};
            M5: info = '{two_ops: 1'b0, wr: 2'b00, pol: 2'b00, down: 1'b0};
            default: info = '0;
        endcase
        return info;
    endfunction

    function automatic logic elem_down(input elem_t e);
        elem_info_t info;
        info = elem_info(e);
        return info.down;
    endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Loadable up/down address counter for the March sequence.
// last_o flags the final address in the current direction.
module mbist_addr_gen #(
    parameter int A_W     = 16,
    parameter int N_WORDS = 16
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           load_up_i,
    input  logic           load_down_i,
    input  logic           step_i,
    input  logic           down_i,
    output logic [A_W-1:0] addr_o,
    output logic           last_o
);

    localparam logic [A_W-1:0] LAST_ADDR = A_W'(N_WORDS - 1);

    logic [A_W-1:0] addr_q;
    logic [A_W-1:0] addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load_up_i) begin
            addr_d = '0;
        end else if (load_down_i) begin
            addr_d = LAST_ADDR;
        end else if (step_i) begin
            addr_d = down_i ? addr_q - 1'b1 : addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= '0;
        end else begin
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = down_i ? (addr_q == '0) : (addr_q == LAST_ADDR);

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST controller: sequences two-cycle memory slots over all
// elements, compares read data and records the first failing location.
module mbist_march_ctrl #(
    parameter int             D_W     = 32,
    parameter int             A_W     = 16,
    parameter int             N_WORDS = 16,
    parameter logic [D_W-1:0] BG      = '0
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_start,
    output logic           o_busy,
    output logic           o_done,
    output logic           o_fail,
    output logic [2:0]     o_fail_elem,
    output logic [A_W-1:0] o_fail_addr,
    output logic [D_W-1:0] o_fail_data,
    output logic [15:0]    o_err_cnt,
    output logic [D_W-1:0] o_mem_data,
    output logic [A_W-1:0] o_mem_addr,
    output logic           o_mem_en,
    output logic           o_mem_wr_rbar,
    input  logic [D_W-1:0] i_mem_out
);

    import mbist_pkg::*;

    state_t         state_q, state_d;
    elem_t          elem_q, elem_d;
    logic           op_q, op_d;
    logic           hold_q, hold_d;
    logic           fail_q, fail_d;
    elem_t          fail_elem_q, fail_elem_d;
    logic [A_W-1:0] fail_addr_q, fail_addr_d;
    logic [D_W-1:0] fail_data_q, fail_data_d;
    logic [15:0]    err_cnt_q, err_cnt_d;

    logic           load_up;
    logic           load_down;
    logic           step;
    logic [A_W-1:0] addr;
    logic           addr_last;

    elem_info_t     info;
    elem_t          elem_nxt;
    logic           in_run;
    logic           cur_wr;
    logic           last_op;
    logic [D_W-1:0] pat;
    logic           mismatch;

    assign info     = elem_info(elem_q);
    assign elem_nxt = elem_q + 3'd1;
    assign in_run   = (state_q == ST_RUN);
    assign cur_wr   = info.wr[op_q];
    assign last_op  = !info.two_ops || op_q;
    assign pat      = info.pol[op_q] ? ~BG : BG;

    // read data from the issue-cycle access is valid during the hold cycle
    assign mismatch = in_run && hold_q && !cur_wr && (i_mem_out != pat);

    mbist_addr_gen #(
        .A_W     (A_W),
        .N_WORDS (N_WORDS)
    ) u_addr_gen (
        .clk_i       (i_clk),
        .rst_i       (i_rst),
        .load_up_i   (load_up),
        .load_down_i (load_down),
        .step_i      (step),
        .down_i      (info.down),
        .addr_o      (addr),
        .last_o      (addr_last)
    );

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        op_d        = op_q;
        hold_d      = hold_q;
        fail_d      = fail_q;
        fail_elem_d = fail_elem_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        err_cnt_d   = err_cnt_q;
        load_up     = 1'b0;
        load_down   = 1'b0;
        step        = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_start) begin
                    state_d     = ST_RUN;
                    elem_d      = M0;
                    op_d        = 1'b0;
                    hold_d      = 1'b0;
                    load_up     = 1'b1;
                    fail_d      = 1'b0;
                    fail_elem_d = '0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                    err_cnt_d   = '0;
                end
            end
            ST_RUN: begin
                hold_d = !hold_q;
                if (hold_q) begin
                    if (!last_op) begin
                        op_d = 1'b1;
                    end else begin
                        op_d = 1'b0;
                        if (!addr_last) begin
                            step = 1'b1;
                        end else if (elem_q == M5) begin
                            state_d = ST_DONE;
                        end else begin
                            elem_d    = elem_nxt;
                            load_up   = !elem_down(elem_nxt);
                            load_down = elem_down(elem_nxt);
                        end
                    end
                end
                if (mismatch) begin
                    if (err_cnt_q != 16'hFFFF) begin
                        err_cnt_d = err_cnt_q + 16'd1;
                    end
                    if (!fail_q) begin
                        fail_d      = 1'b1;
                        fail_elem_d = elem_q;
                        fail_addr_d = addr;
                        fail_data_d = i_mem_out;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            elem_q      <= M0;
            op_q        <= 1'b0;
            hold_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_elem_q <= '0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            op_q        <= op_d;
            hold_q      <= hold_d;
            fail_q      <= fail_d;
            fail_elem_q <= fail_elem_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign o_busy        = in_run;
    assign o_done        = (state_q == ST_DONE);
    assign o_fail        = fail_q;
    assign o_fail_elem   = fail_elem_q;
    assign o_fail_addr   = fail_addr_q;
    assign o_fail_data   = fail_data_q;
    assign o_err_cnt     = err_cnt_q;
    assign o_mem_en      = in_run;
    assign o_mem_wr_rbar = in_run && cur_wr;
    assign o_mem_data    = in_run ? pat : '0;
    assign o_mem_addr    = in_run ? addr : '0;

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: fault-injectable word memory, op and result
// scoreboards fed at start, drained as the bus and done flag appear.
module tb_mbist_march_ctrl;

    localparam int D_W = 32;
    localparam int A_W = 16;
    localparam int N   = 16;
    localparam logic [D_W-1:0] BGV = '0;

    typedef struct packed {
        logic           wr;
        logic [A_W-1:0] addr;
        logic [D_W-1:0] data;
    } op_t;

    typedef struct packed {
        logic           fail;
        logic [2:0]     elem;
        logic [A_W-1:0] addr;
        logic [D_W-1:0] data;
        logic [15:0]    cnt;
    } res_t;

    logic           clk;
    logic           rst;
    logic           start;
    logic           busy, done, fail;
    logic [2:0]     fail_elem;
    logic [A_W-1:0] fail_addr;
    logic [D_W-1:0] fail_data;
    logic [15:0]    err_cnt;
    logic [D_W-1:0] mem_data;
    logic [A_W-1:0] mem_addr;
    logic           mem_en;
    logic           mem_wr;
    logic [D_W-1:0] mem_out;

    int n_checks = 0;
    int n_errors = 0;

    op_t  op_q[$];
    res_t res_q[$];

    logic           f_en;
    logic [A_W-1:0] f_addr;
    int             f_bit;
    logic           f_val;
    logic [D_W-1:0] mem [N];
    logic [D_W-1:0] rd_tmp;

    mbist_march_ctrl #(
        .D_W     (D_W),
        .A_W     (A_W),
        .N_WORDS (N),
        .BG      (BGV)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .o_busy        (busy),
        .o_done        (done),
        .o_fail        (fail),
        .o_fail_elem   (fail_elem),
        .o_fail_addr   (fail_addr),
        .o_fail_data   (fail_data),
        .o_err_cnt     (err_cnt),
        .o_mem_data    (mem_data),
        .o_mem_addr    (mem_addr),
        .o_mem_en      (mem_en),
        .o_mem_wr_rbar (mem_wr),
        .i_mem_out     (mem_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // stuck-at fault applied on the read path only
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_wr) begin
                mem[mem_addr[3:0]] <= mem_data;
            end else begin
                rd_tmp = mem[mem_addr[3:0]];
                if (f_en && mem_addr == f_addr) rd_tmp[f_bit] = f_val;
                mem_out <= rd_tmp;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_op(input logic wr, input int a, input logic pol);
        op_t o;
        o.wr   = wr;
        o.addr = A_W'(a);
        o.data = pol ? ~BGV : BGV;
        op_q.push_back(o);
    endtask

    task automatic build_ops();
        for (int a = 0; a < N; a++) push_op(1'b1, a, 1'b0);
        for (int a = 0; a < N; a++) begin
            push_op(1'b0, a, 1'b0); push_op(1'b1, a, 1'b1);
        end
        for (int a = 0; a < N; a++) begin
            push_op(1'b0, a, 1'b1); push_op(1'b1, a, 1'b0);
        end
        for (int a = N - 1; a >= 0; a--) begin
            push_op(1'b0, a, 1'b0); push_op(1'b1, a, 1'b1);
        end
        for (int a = N - 1; a >= 0; a--) begin
            push_op(1'b0, a, 1'b1); push_op(1'b1, a, 1'b0);
        end
        for (int a = 0; a < N; a++) push_op(1'b0, a, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_fail"}, fail, 0);
        check({tag, "_felem"}, fail_elem, 0);
        check({tag, "_faddr"}, fail_addr, 0);
        check({tag, "_fdata"}, fail_data, 0);
        check({tag, "_errcnt"}, err_cnt, 0);
        check({tag, "_mdata"}, mem_data, 0);
        check({tag, "_maddr"}, mem_addr, 0);
        check({tag, "_men"}, mem_en, 0);
        check({tag, "_mwr"}, mem_wr, 0);
    endtask

    task automatic run_march(input int rst_at, input int pulse_at,
                             input res_t exp_r);
        op_t  cur;
        res_t r;
        int   n;
        bit   done_seen;
        bit   aborted;
        cur = '0;
        op_q.delete();
        build_ops();
        res_q.push_back(exp_r);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        done_seen = 0;
        aborted = 0;
        while (!done_seen && !aborted && n < 400) begin
            if (done) begin
                check("done_cycle", n, 320);
                check("busy_at_done", busy, 0);
                check("bus_idle_done", {mem_en, mem_wr, mem_addr}, 0);
                check("ops_left", op_q.size(), 0);
                if (res_q.size() == 0) begin
                    check("res_missing", 1, 0);
                end else begin
                    r = res_q.pop_front();
                    check("fail", fail, r.fail);
                    check("fail_elem", fail_elem, r.elem);
                    check("fail_addr", fail_addr, r.addr);
                    check("fail_data", fail_data, r.data);
                    check("err_cnt", err_cnt, r.cnt);
                end
                done_seen = 1;
            end else begin
                if (n == 0) begin
                    check("start_fail_clr", fail, 0);
                    check("start_cnt_clr", err_cnt, 0);
                    check("start_cap_clr", {fail_elem, fail_addr, fail_data}, 0);
                end
                if (n % 2 == 0) begin
                    if (op_q.size() == 0) check("op_extra", 1, 0);
                    else cur = op_q.pop_front();
                end
                check("busy", busy, 1);
                check("mem_en", mem_en, 1);
                check("mem_wr", mem_wr, cur.wr);
                check("mem_addr", mem_addr, cur.addr);
                if (cur.wr) check("mem_data", mem_data, cur.data);
                if (n == rst_at) begin
                    rst = 1'b1;
                    #1;
                    check_all_zero("midrst");
                    op_q.delete();
                    res_q.delete();
                    aborted = 1;
                end
                if (n == pulse_at) start = 1'b1;
            end
            if (!done_seen && !aborted) begin
                @(negedge clk);
                start = 1'b0;
                n++;
            end
        end
        if (aborted) begin
            @(negedge clk);
            rst = 1'b0;
        end else if (!done_seen) begin
            check("done_timeout", n, 320);
        end
    endtask

    initial begin
        res_t ok;
        res_t e;
        rst   = 1'b1;
        start = 1'b0;
        f_en  = 1'b0;
        f_addr = '0;
        f_bit = 0;
        f_val = 1'b0;
        #1;
        check_all_zero("rst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("idle");

        ok = '0;
        run_march(-1, -1, ok);

        f_en = 1'b1; f_addr = 16'd3; f_bit = 5; f_val = 1'b0;
        e = '{fail: 1'b1, elem: 3'd2, addr: 16'd3,
              data: 32'hFFFF_FFDF, cnt: 16'd2};
        run_march(-1, -1, e);

        f_addr = 16'd15; f_bit = 0; f_val = 1'b1;
        e = '{fail: 1'b1, elem: 3'd1, addr: 16'd15,
              data: 32'h0000_0001, cnt: 16'd3};
        run_march(-1, -1, e);

        f_en = 1'b0;
        run_march(100, -1, ok);
        repeat (2) @(negedge clk);
        check_all_zero("after_rst");
        run_march(-1, -1, ok);
        run_march(-1, 150, ok);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
